// File: rtl/tile_seq_pkg.sv
// Shared types and width defaults for the tile operation sequencer.
package tile_seq_pkg;

    localparam int unsigned DEFAULT_ROWS_W  = 8;
    localparam int unsigned DEFAULT_SHIFT_W = 6;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } seq_state_e;

    typedef struct packed {
        logic [DEFAULT_ROWS_W-1:0]  rows;
        logic [DEFAULT_SHIFT_W-1:0] shift;
        logic                       flip;
    } seq_cmd_t;

endpackage

// File: rtl/tile_row_counter.sv
// Row counter: cleared on load, stepped by inc, compared against the command's row count.
module tile_row_counter #(
    parameter int unsigned W = 9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] target,
    output logic         below,
    output logic         hit_next
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign below    = count_q < target;
    // True when this cycle's increment (if any) lands exactly on the target.
    assign hit_next = (count_q + W'(inc)) == target;

endmodule

// File: rtl/tile_op_sequencer.sv
// Sequences one tile through preload/compute commands: gates operand rows into the tile,
// holds propagate/shift stable per command, and counts results back to signal completion.
module tile_op_sequencer
    import tile_seq_pkg::*;
#(
    parameter int unsigned ROWS_W       = DEFAULT_ROWS_W,
    parameter int unsigned SHIFT_W      = DEFAULT_SHIFT_W,
    parameter int unsigned TILE_LATENCY = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ROWS_W-1:0]  cmd_rows,
    input  logic [SHIFT_W-1:0] cmd_shift,
    input  logic               cmd_flip,
    input  logic               op_valid,
    output logic               op_ready,
    output logic               io_in_valid_0,
    output logic               io_in_control_0_propagate,
    output logic [SHIFT_W-1:0] io_in_control_0_shift,
    input  logic               io_out_valid_0,
    output logic               op_done,
    output logic               busy
);

    // One extra bit so a full 2^ROWS_W-1 row command never wraps.
    localparam int unsigned CNT_W = ROWS_W + 1;

    if (TILE_LATENCY == 0) begin : g_latency_check
        $error("TILE_LATENCY must be at least 1");
    end

    seq_state_e         state_q, state_d;
    logic [ROWS_W-1:0]  rows_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               prop_q;

    logic             accept;
    logic             ret;
    logic             issue_below;
    logic             issue_last;
    logic             ret_last;
    logic [CNT_W-1:0] target;

    assign target    = {1'b0, rows_q};
    assign cmd_ready = (state_q == StIdle);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q != StIdle);

    assign op_ready      = (state_q == StRun) && issue_below;
    assign io_in_valid_0 = op_valid && op_ready;
    // Results arriving while idle are stray and must not disturb the counters.
    assign ret           = io_out_valid_0 && busy;

    assign io_in_control_0_propagate = prop_q;
    assign io_in_control_0_shift     = shift_q;

    tile_row_counter #(
        .W (CNT_W)
    ) u_issue_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .inc      (io_in_valid_0),
        .target   (target),
        .below    (issue_below),
        .hit_next (issue_last)
    );

    tile_row_counter #(
        .W (CNT_W)
    ) u_return_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .inc      (ret),
        .target   (target),
        .below    (),
        .hit_next (ret_last)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            rows_q  <= '0;
            shift_q <= '0;
            prop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rows_q  <= cmd_rows;
                shift_q <= cmd_shift;
                prop_q  <= prop_q ^ cmd_flip;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // A zero-row command completes here on its first cycle.
                if (ret_last) begin
                    op_done = 1'b1;
                    state_d = StIdle;
                end else if (io_in_valid_0 && issue_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (ret_last) begin
                    op_done = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_tile_op_sequencer.sv
// Directed bench for tile_op_sequencer: delay-line tile model plus a scoreboard of expected
// tile rows (cycle, propagate, shift) and expected op_done cycles.
module tb_tile_op_sequencer;
    import tile_seq_pkg::*;

    localparam int unsigned ROWS_W  = DEFAULT_ROWS_W;
    localparam int unsigned SHIFT_W = DEFAULT_SHIFT_W;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [ROWS_W-1:0]  cmd_rows = '0;
    logic [SHIFT_W-1:0] cmd_shift = '0;
    logic               cmd_flip = 1'b0;
    logic               op_valid = 1'b0;
    logic               op_ready;
    logic               io_in_valid_0;
    logic               io_in_control_0_propagate;
    logic [SHIFT_W-1:0] io_in_control_0_shift;
    logic               io_out_valid_0;
    logic               op_done;
    logic               busy;

    tile_op_sequencer #(
        .ROWS_W       (ROWS_W),
        .SHIFT_W      (SHIFT_W),
        .TILE_LATENCY (1)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .cmd_valid                 (cmd_valid),
        .cmd_ready                 (cmd_ready),
        .cmd_rows                  (cmd_rows),
        .cmd_shift                 (cmd_shift),
        .cmd_flip                  (cmd_flip),
        .op_valid                  (op_valid),
        .op_ready                  (op_ready),
        .io_in_valid_0             (io_in_valid_0),
        .io_in_control_0_propagate (io_in_control_0_propagate),
        .io_in_control_0_shift     (io_in_control_0_shift),
        .io_out_valid_0            (io_out_valid_0),
        .op_done                   (op_done),
        .busy                      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        int prop;
        int shift;
    } exp_row_t;

    exp_row_t   exp_rows[$];
    int         exp_done[$];
    int         cyc = 0;
    int         lat = 1;
    logic [7:0] pipe = '0;
    int         errors = 0;
    int         checks = 0;
    int         prop_m = 0;
    int         valid_count = 0;

    // Tile model: io_out_valid_0 follows io_in_valid_0 by lat cycles.
    always @(posedge clock) begin
        cyc  <= cyc + 1;
        pipe <= {pipe[6:0], io_in_valid_0};
    end
    assign io_out_valid_0 = pipe[lat-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        exp_row_t e;
        if (io_in_valid_0) begin
            valid_count++;
            if (exp_rows.size() == 0) begin
                check("unexpected_valid", cyc, 32'hffff_ffff);
            end else begin
                e = exp_rows.pop_front();
                check("valid_cycle", cyc, e.cyc);
                check("valid_propagate", {31'd0, io_in_control_0_propagate}, e.prop);
                check("valid_shift", {26'd0, io_in_control_0_shift}, e.shift);
            end
        end
        if (op_done) begin
            if (exp_done.size() == 0) begin
                check("unexpected_op_done", cyc, 32'hffff_ffff);
            end else begin
                check("op_done_cycle", cyc, exp_done.pop_front());
            end
        end
    end

    // Issues one command from IDLE, drives op_valid by pat (then held high), and waits
    // until one cycle past the predicted op_done.
    task automatic run_cmd(input int rows, input int shift, input bit flip,
                           input logic [7:0] pat, input int patlen, output int low);
        int a, k, issued, last, done_cyc;
        check("cmd_ready_before_cmd", {31'd0, cmd_ready}, 1);
        a         = cyc;
        cmd_valid = 1'b1;
        cmd_rows  = ROWS_W'(rows);
        cmd_shift = SHIFT_W'(shift);
        cmd_flip  = flip;
        prop_m    = prop_m ^ int'(flip);
        k         = 0;
        issued    = 0;
        last      = a;
        while (issued < rows) begin
            if (k >= patlen || pat[k]) begin
                exp_rows.push_back('{cyc: a + 1 + k, prop: prop_m, shift: shift});
                issued++;
                last = a + 1 + k;
            end
            k++;
        end
        done_cyc = (rows == 0) ? a + 1 : last + lat;
        exp_done.push_back(done_cyc);
        step();
        cmd_valid = 1'b0;
        cmd_flip  = 1'b0;
        low       = 0;
        for (int j = 0; cyc <= done_cyc; j++) begin
            op_valid = (j >= patlen) ? 1'b1 : pat[j];
            if (cmd_ready == 1'b0) low++;
            step();
        end
        op_valid = 1'b0;
        check("op_done_seen", exp_done.size(), 0);
        check("rows_all_issued", exp_rows.size(), 0);
        check("cmd_ready_low_cycles", low, done_cyc - a);
        check("cmd_ready_after_done", {31'd0, cmd_ready}, 1);
        check("busy_after_done", {31'd0, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low, a, vc;

        // Reset values
        repeat (2) step();
        reset = 1'b1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        check("rst_op_ready", {31'd0, op_ready}, 0);
        check("rst_in_valid", {31'd0, io_in_valid_0}, 0);
        check("rst_propagate", {31'd0, io_in_control_0_propagate}, 0);
        check("rst_shift", {26'd0, io_in_control_0_shift}, 0);
        check("rst_op_done", {31'd0, op_done}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        step();

        // Single command, op_valid held high; first of the flip 1,0,1 sequence
        run_cmd(4, 3, 1'b1, 8'h00, 0, low);
        check("t1_cmd_ready_low_5", low, 5);
        check("t1_propagate", {31'd0, io_in_control_0_propagate}, 1);

        // Shift must not follow cmd_shift outside of accept
        cmd_shift = 6'd9;
        step();
        check("shift_hold_idle", {26'd0, io_in_control_0_shift}, 3);

        run_cmd(2, 9, 1'b0, 8'h00, 0, low);
        check("t2_propagate", {31'd0, io_in_control_0_propagate}, 1);
        check("t2_shift", {26'd0, io_in_control_0_shift}, 9);
        run_cmd(2, 12, 1'b1, 8'h00, 0, low);
        check("t3_propagate", {31'd0, io_in_control_0_propagate}, 0);
        check("t3_shift", {26'd0, io_in_control_0_shift}, 12);

        // Stalled feeder: op_valid 1,0,0,1,1
        run_cmd(3, 5, 1'b0, 8'b0001_1001, 5, low);

        // Zero-row command
        vc = valid_count;
        run_cmd(0, 2, 1'b0, 8'h00, 0, low);
        check("zero_rows_no_valid", valid_count - vc, 0);
        check("zero_rows_shift", {26'd0, io_in_control_0_shift}, 2);

        // Reset after 5 of 8 issues
        step();
        check("mid_cmd_ready", {31'd0, cmd_ready}, 1);
        a         = cyc;
        cmd_valid = 1'b1;
        cmd_rows  = 8'd8;
        cmd_shift = 6'd4;
        cmd_flip  = 1'b1;
        prop_m    = prop_m ^ 1;
        for (int i = 0; i < 5; i++) begin
            exp_rows.push_back('{cyc: a + 1 + i, prop: prop_m, shift: 4});
        end
        step();
        cmd_valid = 1'b0;
        cmd_flip  = 1'b0;
        op_valid  = 1'b1;
        repeat (5) step();
        op_valid = 1'b0;
        reset    = 1'b0;
        step();
        reset  = 1'b1;
        prop_m = 0;
        check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 1);
        check("mid_rst_op_ready", {31'd0, op_ready}, 0);
        check("mid_rst_in_valid", {31'd0, io_in_valid_0}, 0);
        check("mid_rst_propagate", {31'd0, io_in_control_0_propagate}, 0);
        check("mid_rst_shift", {26'd0, io_in_control_0_shift}, 0);
        check("mid_rst_op_done", {31'd0, op_done}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        repeat (4) step();
        check("mid_rst_rows_issued", exp_rows.size(), 0);
        check("mid_rst_no_done", exp_done.size(), 0);

        // Max rows through a 3-cycle tile
        lat = 3;
        vc  = valid_count;
        run_cmd(255, 17, 1'b0, 8'h00, 0, low);
        check("max_rows_valids", valid_count - vc, 255);
        check("max_rows_low", low, 258);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
